// File: rtl/layer_pkg.sv
// ============================================================================
// Module   : layer_pkg
// Purpose  : Shared types and constants for the layer result collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package layer_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam logic MODE_SUMMED = 1'b0;
    localparam logic MODE_ELLIOT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : layer_pkg

`default_nettype wire

// File: rtl/layer_result_slot.sv
// ============================================================================
// Module   : layer_result_slot
// Purpose  : One channel's result buffer: source select, hold register,
//            pending flag and (with LAYER_RESULT_OVERRUN_EN) overrun detect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module layer_result_slot
    import layer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              capture_en,
    input  logic              mode_sel,
    input  logic [DATA_W-1:0] summed_data,
    input  logic              summed_done,
    input  logic [DATA_W-1:0] elliot_data,
    input  logic              elliot_done,
    input  logic              drain,
    output logic [DATA_W-1:0] hold,
    output logic              pending
`ifdef LAYER_RESULT_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;
    logic              pending_q;
    logic              pending_d;
    logic              sel_done;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel_done  = (mode_sel == MODE_ELLIOT) ? elliot_done : summed_done;
        sel_data  = (mode_sel == MODE_ELLIOT) ? elliot_data : summed_data;
        hold_d    = hold_q;
        pending_d = pending_q;
`ifdef LAYER_RESULT_OVERRUN_EN
        overrun   = 1'b0;
`endif
        if (clear) begin
            pending_d = 1'b0;
        end else if (capture_en) begin
            if (drain) begin
                pending_d = 1'b0;
            end
            if (sel_done) begin
                if (!pending_q) begin
                    hold_d    = sel_data;
                    pending_d = 1'b1;
                end else begin
                    // A strobe on an occupied slot (even one draining this cycle)
`ifdef LAYER_RESULT_OVERRUN_EN
                    overrun   = 1'b1;
`else
                    hold_d    = sel_data;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            pending_q <= pending_d;
        end
    end

    assign hold    = hold_q;
    assign pending = pending_q;

endmodule : layer_result_slot

`default_nettype wire

// File: rtl/layer_result_collector.sv
// ============================================================================
// Module   : layer_result_collector
// Purpose  : Buffers one result per neuron channel and drains them in index
//            order. Optional overrun flag: LAYER_RESULT_OVERRUN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module layer_result_collector
    import layer_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int N_CH   = 4,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [N_CH*DATA_W-1:0] summed_data,
    input  logic [N_CH-1:0]        summed_done,
    input  logic [N_CH*DATA_W-1:0] elliot_data,
    input  logic [N_CH-1:0]        elliot_done,
    output logic [DATA_W-1:0]      out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   layer_done,
    output logic                   err_overrun
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   ptr_d;
    logic              mode_q;
    logic              mode_d;
    logic              clear_slots;
    logic              xfer;
    logic              capture_en;
    logic [N_CH-1:0]   pending;
    logic [DATA_W-1:0] hold [N_CH];
`ifdef LAYER_RESULT_OVERRUN_EN
    logic [N_CH-1:0]   overrun;
    logic              err_overrun_q;
    logic              err_overrun_d;
`endif

    assign capture_en = (state_q == RUN);
    assign out_valid  = capture_en && pending[ptr_q];
    assign out_data   = hold[ptr_q];
    assign out_ch     = ptr_q;
    assign xfer       = out_valid && out_ready;
    assign busy       = (state_q == RUN) || (state_q == DONE);
    assign layer_done = (state_q == DONE);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_slot
            layer_result_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .clear       (clear_slots),
                .capture_en  (capture_en),
                .mode_sel    (mode_q),
                .summed_data (summed_data[i*DATA_W +: DATA_W]),
                .summed_done (summed_done[i]),
                .elliot_data (elliot_data[i*DATA_W +: DATA_W]),
                .elliot_done (elliot_done[i]),
                .drain       (xfer && (ptr_q == CH_W'(i))),
                .hold        (hold[i]),
                .pending     (pending[i])
`ifdef LAYER_RESULT_OVERRUN_EN
                ,
                .overrun     (overrun[i])
`endif
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mode_d      = mode_q;
        clear_slots = 1'b0;
`ifdef LAYER_RESULT_OVERRUN_EN
        err_overrun_d = err_overrun_q | (capture_en && (|overrun));
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    ptr_d       = '0;
                    clear_slots = 1'b1;
                    state_d     = RUN;
`ifdef LAYER_RESULT_OVERRUN_EN
                    err_overrun_d = 1'b0;
`endif
                end
            end
            RUN: begin
                // ptr parks on the last channel rather than wrapping
                if (xfer) begin
                    if (ptr_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = ptr_q + CH_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mode_q  <= MODE_SUMMED;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
        end
    end

`ifdef LAYER_RESULT_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overrun_q <= 1'b0;
        end else begin
            err_overrun_q <= err_overrun_d;
        end
    end

    assign err_overrun = err_overrun_q;
`else
    assign err_overrun = 1'b0;
`endif

endmodule : layer_result_collector

`default_nettype wire

// File: tb/tb_layer_result_collector.sv
// ============================================================================
// Module   : tb_layer_result_collector
// Purpose  : Scoreboard bench for layer_result_collector (N_CH=4, DATA_W=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_layer_result_collector;

    localparam int DATA_W = 32;
    localparam int N_CH   = 4;
    localparam int CH_W   = 2;

`ifdef LAYER_RESULT_OVERRUN_EN
    localparam logic        OVR_FLAG = 1'b1;
    localparam logic [31:0] OVR_DATA = 32'h22;
`else
    localparam logic        OVR_FLAG = 1'b0;
    localparam logic [31:0] OVR_DATA = 32'h33;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   mode;
    logic [N_CH*DATA_W-1:0] summed_data;
    logic [N_CH-1:0]        summed_done;
    logic [N_CH*DATA_W-1:0] elliot_data;
    logic [N_CH-1:0]        elliot_done;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   layer_done;
    logic                   err_overrun;

    typedef struct {
        bit          is_done;
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    layer_result_collector #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .summed_data (summed_data),
        .summed_done (summed_done),
        .elliot_data (elliot_data),
        .elliot_done (elliot_done),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .layer_done  (layer_done),
        .err_overrun (err_overrun)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        mode        = 1'b0;
        summed_done = '0;
        elliot_done = '0;
        summed_data = '0;
        elliot_data = '0;
        out_ready   = 1'b0;
    endtask

    task automatic recover();
        rst = 1'b1;
        exp_q.delete();
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: pops the expected stream on every transfer and layer_done.
    initial begin
        bit          pv;
        logic [31:0] pd;
        logic [1:0]  pc;
        exp_t        e;
        pv = 1'b0;
        pd = '0;
        pc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            if (pv) begin
                checks++;
                if (!out_valid || out_data !== pd || out_ch !== pc) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b data=%h ch=%0d, required valid=1 data=%h ch=%0d",
                             out_valid, out_data, out_ch, pd, pc);
                end
            end
            pv = out_valid && !out_ready;
            pd = out_data;
            pc = out_ch;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    errors++;
                    $display("FAIL xfer_unexpected: got ch=%0d data=%h, required no transfer", out_ch, out_data);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    e = exp_q.pop_front();
                    if (out_ch !== e.ch[1:0] || out_data !== e.data) begin
                        errors++;
                        $display("FAIL xfer_word: got ch=%0d data=%h, required ch=%0d data=%h",
                                 out_ch, out_data, e.ch, e.data);
                    end
                end
            end
            if (layer_done) begin
                done_cnt++;
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    errors++;
                    $display("FAIL layer_done_early: got pulse with %0d words outstanding, required 0",
                             exp_q.size());
                    exp_q.delete();
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Run one layer: d[i] is channel i's selected result, strobed at cycle sc[i].
    // rdy_mode: 0 = always ready, 1 = random ready, 2 = stalled for cycles 1..6.
    task automatic do_layer(input logic m, input logic [31:0] d [N_CH],
                            input int sc [N_CH], input int rdy_mode);
        int base;
        int cyc;
        for (int i = 0; i < N_CH; i++) exp_q.push_back('{1'b0, i, d[i]});
        exp_q.push_back('{1'b1, 0, 32'h0});
        base  = done_cnt;
        start = 1'b1;
        mode  = m;
        tick();
        cyc = 1;
        while (done_cnt == base && cyc < 300) begin
            start       = (cyc == 1);
            mode        = ~m;
            summed_done = '0;
            elliot_done = '0;
            for (int i = 0; i < N_CH; i++) begin
                logic sel_hit;
                logic oth_hit;
                sel_hit = (sc[i] == cyc);
                oth_hit = ($urandom_range(0, 1) == 1);
                if (m) begin
                    elliot_done[i] = sel_hit;
                    elliot_data[i*DATA_W +: DATA_W] = sel_hit ? d[i] : $urandom;
                    summed_done[i] = oth_hit;
                    summed_data[i*DATA_W +: DATA_W] = 32'hFF;
                end else begin
                    summed_done[i] = sel_hit;
                    summed_data[i*DATA_W +: DATA_W] = sel_hit ? d[i] : $urandom;
                    elliot_done[i] = oth_hit;
                    elliot_data[i*DATA_W +: DATA_W] = 32'hFF;
                end
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (cyc > 6);
            endcase
            @(negedge clk);
            if (cyc == 1) begin
                chk("err_clear_on_start", {31'b0, err_overrun}, 32'd0);
                chk("busy_in_run", {31'b0, busy}, 32'd1);
            end
            if (rdy_mode == 2 && cyc >= 2 && cyc <= 6)
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
            tick();
            cyc++;
        end
        idle_inputs();
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL layer_timeout: got no layer_done in %0d cycles, required one", cyc);
            recover();
        end else begin
            @(negedge clk);
            chk("busy_after_done", {31'b0, busy}, 32'd0);
            tick();
        end
    endtask

    task automatic do_overrun();
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d3;
        int          base;
        int          cyc;
        d0 = $urandom;
        d1 = $urandom;
        d3 = $urandom;
        exp_q.push_back('{1'b0, 0, d0});
        exp_q.push_back('{1'b0, 1, d1});
        exp_q.push_back('{1'b0, 2, OVR_DATA});
        exp_q.push_back('{1'b0, 3, d3});
        exp_q.push_back('{1'b1, 0, 32'h0});
        base  = done_cnt;
        start = 1'b1;
        mode  = 1'b0;
        tick();
        start = 1'b0;
        summed_done = 4'b0100;
        summed_data[2*DATA_W +: DATA_W] = 32'h22;
        tick();
        summed_done = 4'b0111;
        summed_data[0*DATA_W +: DATA_W] = d0;
        summed_data[1*DATA_W +: DATA_W] = d1;
        summed_data[2*DATA_W +: DATA_W] = 32'h33;
        tick();
        summed_done = '0;
        @(negedge clk);
        chk("err_overrun_flag", {31'b0, err_overrun}, {31'b0, OVR_FLAG});
        tick();
        summed_done = 4'b1000;
        summed_data[3*DATA_W +: DATA_W] = d3;
        out_ready = 1'b1;
        tick();
        summed_done = '0;
        cyc = 0;
        while (done_cnt == base && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL overrun_timeout: got no layer_done in %0d cycles, required one", cyc);
            recover();
        end
        chk("err_overrun_sticky", {31'b0, err_overrun}, {31'b0, OVR_FLAG});
        idle_inputs();
        tick();
    endtask

    initial begin
        logic [31:0] d [N_CH];
        int          sc [N_CH];

        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ch", {30'b0, out_ch}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_layer_done", {31'b0, layer_done}, 32'd0);
        chk("rst_err_overrun", {31'b0, err_overrun}, 32'd0);
        tick();

        // Done strobes while idle must not produce output.
        for (int c = 0; c < 3; c++) begin
            summed_done = '1;
            elliot_done = '1;
            summed_data = {4{32'hDEAD_BEEF}};
            out_ready   = 1'b1;
            @(negedge clk);
            chk("idle_no_valid", {31'b0, out_valid}, 32'd0);
            chk("idle_not_busy", {31'b0, busy}, 32'd0);
            tick();
        end
        idle_inputs();

        for (int i = 0; i < N_CH; i++) begin
            d[i]  = 32'h10 + i;
            sc[i] = i + 1;
        end
        do_layer(1'b0, d, sc, 0);

        for (int i = 0; i < N_CH; i++) d[i] = 32'hA0 + i;
        sc[0] = 3; sc[1] = 2; sc[2] = 4; sc[3] = 1;
        do_layer(1'b1, d, sc, 0);

        for (int i = 0; i < N_CH; i++) d[i] = $urandom;
        sc[0] = 1; sc[1] = 8; sc[2] = 9; sc[3] = 10;
        do_layer(1'b0, d, sc, 2);

        do_overrun();

        // Reset mid-layer after two channels have been captured.
        start = 1'b1;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        elliot_done = 4'b0011;
        elliot_data = {4{32'h5A5A_0000}};
        tick();
        elliot_done = '0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_layer_done", {31'b0, layer_done}, 32'd0);
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N_CH; i++) begin
                d[i]  = $urandom;
                sc[i] = $urandom_range(1, 10);
            end
            do_layer(1'($urandom_range(0, 1)), d, sc, (n % 3 == 0) ? 0 : 1);
        end

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_layer_result_collector

`default_nettype wire

// File: doc/layer_result_collector.md
# layer_result_collector

Parametrised successor to the single-neuron layer output select. Collects one result per neuron from N_CH neuron channels. Each channel has a summed-input source and an Elliot-activation source; a per-layer mode chooses which one is used. Results are buffered per channel and drained in neuron-index order over a valid/ready stream, with a layer-complete pulse, between a layer's neuron array and the next layer's input loader.

## Interface
- DATA_W, 32, width of each result word
- N_CH, 4, neuron channels per layer (≥2)
- CH_W, $clog2(N_CH), channel index width (derived; not overridden)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a layer; honoured only in IDLE
- mode  in  1  source select, sampled on start: 0 = summed, 1 = Elliot
- summed_data  in  N_CH*DATA_W  summed result, channel i at [i*DATA_W +: DATA_W]
- summed_done  in  N_CH  per-channel summed-finished strobe
- elliot_data  in  N_CH*DATA_W  activation result, same packing
- elliot_done  in  N_CH  per-channel activation-finished strobe
- out_data  out  DATA_W  result word of the channel being presented
- out_ch  out  CH_W  index of the channel being presented
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  downstream accepts
- busy  out  1  high in RUN and DONE
- layer_done  out  1  one-cycle pulse after last channel transferred
- err_overrun  out  1  sticky overrun flag (see Configuration)

## Operation
- Reset values: out_valid=0, out_data=0, out_ch=0, busy=0, layer_done=0, err_overrun=0, pending=0, ptr=0, mode_q=0, state=IDLE.
- FSM, three states:
  - IDLE: on start, latch mode_q=mode, clear pending, set ptr=0, go to RUN.
  - RUN: accept results and drain them. Go to DONE on the transfer with ptr==N_CH-1.
  - DONE: layer_done=1 for this single cycle, then IDLE.
- Capture in RUN: for each channel i, sel_done[i] = mode_q ? elliot_done[i] : summed_done[i]. When sel_done[i]=1 and pending[i]=0, hold[i] gets the selected source data and pending[i] is set. Strobes of the non-selected source are ignored.
- Drain: out_valid = (state==RUN) & pending[ptr]; out_data = hold[ptr]; out_ch = ptr. All are driven from registers only, with no combinational path from data or done inputs.
- Transfer = out_valid & out_ready. It clears pending[ptr] and increments ptr. ptr does not wrap inside a layer; it resets to 0 on the next start.
- Channels may complete in any order. Output order is always 0..N_CH-1.
- Done strobes in IDLE or DONE are ignored. start in RUN or DONE is ignored.
- Simultaneous transfer of channel ptr and a new sel_done on the same channel counts as an overrun, because pending is still 1 in that cycle. The new result is dropped.
- rst mid-layer: all state returns to reset values at once. Buffered results are discarded, with no layer_done.

## Timing
- Capture latency: sel_done[i] high at edge k, with i==ptr and pending[i]=0. out_valid is high in the cycle after edge k.
- Throughput: one transfer per cycle when results are already buffered and out_ready=1.
- Minimum layer: start at edge 0, all done strobes at edge 1, out_ready=1. Transfers occur in the cycles after edges 2..N_CH+1, and layer_done is high after edge N_CH+2.
- out_valid may drop only by transfer or reset. out_data and out_ch are stable while out_valid=1 and out_ready=0.

## Configuration
- LAYER_RESULT_OVERRUN_EN defined:
  - sel_done[i] with pending[i]=1 in RUN sets err_overrun.
  - err_overrun is sticky until rst or the next accepted start.
  - The second result is dropped.
- Not defined:
  - err_overrun is tied 0.
  - A sel_done on a pending channel overwrites hold[i] with the new data, and pending stays 1.

## Structure
- Shared package layer_pkg:
  - state enum {IDLE, RUN, DONE}
  - MODE_SUMMED=1'b0 and MODE_ELLIOT=1'b1 constants
  - default DATA_W
- Sub-module layer_result_slot: one channel's hold register, pending flag, source select and overrun detect. Instantiated N_CH times by generate.

## Test plan
- In-order summed: N_CH=4, start mode=0, summed_done[i] at cycle i with data 0x10+i, out_ready=1 → four words 0x10..0x13 with out_ch 0..3, then layer_done pulse, busy=0.
- Out-of-order Elliot: start mode=1, elliot_done order 3,1,0,2 with data 0xA3,0xA1,0xA0,0xA2; summed_done also strobed with 0xFF → output 0xA0,0xA1,0xA2,0xA3 in index order, 0xFF never seen.
- Backpressure: out_ready=0 for 5 cycles with channel 0 pending → out_valid=1 and out_data constant; the transfer occurs on the first cycle out_ready=1.
- Overrun (macro on): channel 2 done twice, 0x22 then 0x33, before drain → err_overrun=1, output for channel 2 is 0x22. With the macro off, output is 0x33 and err_overrun=0.
- Reset mid-layer: rst after 2 of 4 channels captured → next cycle out_valid=0, busy=0, layer_done never pulses. A new start then runs a clean layer.
- Ignored events: start in RUN and done strobes in IDLE → no state change, no output.
